ni_flit_injector: RTL

Transmit side of the network interface that drives the router's local input port. On a start request it fetches a packet (header flit, size flit, payload flits) from a word-addressed local memory and streams it flit by flit onto the credit-based link (`clock_rx`/`rx`/`data_i`/`credit_o` of the router's local port). A 2-entry prefetch buffer hides memory latency so flits go out back-to-back while credit is available.

---
 rtl/ni_flit_injector.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: fetches a packet (header, size, payload) from local memory
// and streams it onto the router's credit-based local input port. A 2-entry
// buffer, plus one read in flight, keeps flits going out back-to-back.
module ni_flit_injector #(
    parameter int FLIT_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [FLIT_WIDTH-1:0] mem_data,
    output logic                  clock_tx,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [16:0]           fetch_idx_q, fetch_idx_d;   // next flit index to read
    logic [16:0]           total_q, total_d;           // T = N + 2
    logic [16:0]           sent_q, sent_d;
    logic                  have_n_q, have_n_d;
    logic [1:0]            ret_cnt_q, ret_cnt_d;       // returns seen, saturates at 2
    logic                  inflight_q, inflight_d;     // mem_data valid this cycle
    logic [1:0]            occ_q, occ_d;
    logic [FLIT_WIDTH-1:0] head_q, head_d;
    logic [FLIT_WIDTH-1:0] tail_q, tail_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  size_ret;
    logic                  n_known;
    logic [16:0]           n_now;
    logic [1:0]            slots;
    logic                  fetch_ok;

    assign clock_tx = clock;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign tx       = (occ_q != 2'd0);
    assign data_o   = head_q;

    // State register; reset aborts any packet in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            fetch_idx_q <= '0;
            total_q     <= '0;
            sent_q      <= '0;
            have_n_q    <= 1'b0;
            ret_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            fetch_idx_q <= fetch_idx_d;
            total_q     <= total_d;
            sent_q      <= sent_d;
            have_n_q    <= have_n_d;
            ret_cnt_q   <= ret_cnt_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            done_q      <= done_d;
        end
    end

    // Next-state: start acceptance, fetch issue, buffer push/pop, completion.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        fetch_idx_d = fetch_idx_q;
        total_d     = total_q;
        sent_d      = sent_q;
        have_n_d    = have_n_q;
        ret_cnt_d   = ret_cnt_q;
        inflight_d  = 1'b0;
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        done_d      = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;

        pop      = (state_q == RUN) && (occ_q != 2'd0) && credit_i;
        // The size flit is the second return; bypass it so payload reads
        // can start in the same cycle it arrives.
        size_ret = inflight_q && (ret_cnt_q == 2'd1);
        n_known  = have_n_q || size_ret;
        n_now    = size_ret ? ({1'b0, mem_data[15:0]} + 17'd2) : total_q;
        // Buffer entries plus read in flight, counting this cycle's pop.
        slots    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        fetch_ok = (fetch_idx_q < 17'd2) || (n_known && (fetch_idx_q < n_now));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    base_d      = base_addr;
                    fetch_idx_d = '0;
                    total_d     = '0;
                    sent_d      = '0;
                    have_n_d    = 1'b0;
                    ret_cnt_d   = '0;
                    occ_d       = '0;
                end
            end
            RUN: begin
                if ((slots < 2'd2) && fetch_ok) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + ADDR_WIDTH'(fetch_idx_q);
                    fetch_idx_d = fetch_idx_q + 17'd1;
                    inflight_d  = 1'b1;
                end

                if (size_ret) begin
                    total_d  = n_now;
                    have_n_d = 1'b1;
                end
                if (inflight_q && (ret_cnt_q != 2'd2))
                    ret_cnt_d = ret_cnt_q + 2'd1;

                case ({inflight_q, pop})
                    2'b10: begin
                        if (occ_q == 2'd0) head_d = mem_data;
                        else               tail_d = mem_data;
                        occ_d = occ_q + 2'd1;
                    end
                    2'b01: begin
                        head_d = tail_q;
                        occ_d  = occ_q - 2'd1;
                    end
                    2'b11: begin
                        if (occ_q == 2'd1) begin
                            head_d = mem_data;
                        end else begin
                            head_d = tail_q;
                            tail_d = mem_data;
                        end
                    end
                    default: ;
                endcase

                if (pop) begin
                    sent_d = sent_q + 17'd1;
                    if ((sent_q + 17'd1) == total_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
